collision_event_arbiter: RTL and testbench

//  Collects per-pixel collision flags from the collision detector during one frame.
//  At each startOfFrame it hands them to game_controller as a serialized stream of

---
 rtl/pinball_pkg.sv | 21 ++
 rtl/event_priority_picker.sv | 36 +++
 rtl/collision_event_arbiter.sv | 179 +++++++++++++++++
 tb/tb_collision_event_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pinball_pkg.sv
// Shared definitions for the pinball collision path: source index map and the
// event arbiter state type.
package pinball_pkg;

    // Collision source indices; index 0 wins under fixed priority
    localparam int SRC_BORDER_BOTTOM = 0;
    localparam int SRC_OBST_BAD      = 1;
    localparam int SRC_OBST_GOOD     = 2;
    localparam int SRC_SPRING        = 3;
    localparam int SRC_FLIPPER       = 4;
    localparam int SRC_BORDER_TOP    = 5;
    localparam int SRC_BORDER_LEFT   = 6;
    localparam int SRC_BORDER_RIGHT  = 7;

    // Arbiter states: IDLE picks a pending source, ISSUE presents it until acked
    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/event_priority_picker.sv
// Combinational picker: scans the request vector starting at i_start and
// wrapping around, returning the first set index. A start of 0 gives plain
// lowest-index priority.
module event_priority_picker #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [ID_W-1:0]    i_start,
    output logic               o_found,
    output logic [ID_W-1:0]    o_idx
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_pos;

    // Wrap-around scan from the start position; first hit wins
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        w_pos   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_sum = {1'b0, i_start} + (ID_W+1)'(i);
            if (w_sum >= (ID_W+1)'(NUM_SRC)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_SRC);
            end
            w_pos = w_sum[ID_W-1:0];
            if (!o_found && i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/collision_event_arbiter.sv
// Collision event arbiter: gathers per-pixel collision flags over a frame, arms
// them at startOfFrame, and serializes them to the game controller as single
// events under a valid/ack handshake. A per-source frame cooldown debounces a
// ball that stays in contact across frames.
//
// Handshake: eventValid rises only from IDLE and stays high with eventId stable
// until the cycle where eventValid && eventAck; that cycle is the transfer.
// eventAck without eventValid has no effect.
//
// Build option: define COLLISION_ROUND_ROBIN_EN for round-robin selection
// starting after the last accepted id; otherwise fixed lowest-index priority.
module collision_event_arbiter
    import pinball_pkg::*;
#(
    parameter int NUM_SRC         = 8,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int CD_W            = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         startOfFrame,
    input  logic                         pause,
    input  logic [NUM_SRC-1:0]           collisionReq,
    input  logic [NUM_SRC-1:0]           srcMask,
    output logic                         eventValid,
    output logic [$clog2(NUM_SRC)-1:0]   eventId,
    input  logic                         eventAck,
    output logic [$clog2(NUM_SRC):0]     pendingCount,
    output logic                         droppedEvent,
    output arb_state_t                   o_dbg_state
);

    localparam int ID_W  = $clog2(NUM_SRC);
    localparam int CNT_W = ID_W + 1;

    logic [NUM_SRC-1:0] r_frame_latch;
    logic [NUM_SRC-1:0] r_pending;
    logic [CD_W-1:0]    r_cd [NUM_SRC];
    logic               r_dropped;
    arb_state_t         r_state;
    logic [ID_W-1:0]    r_id;

    arb_state_t         w_state_next;
    logic [ID_W-1:0]    w_id_next;
    logic               w_ack;
    logic               w_arm_en;
    logic [NUM_SRC-1:0] w_cd_zero;
    logic [NUM_SRC-1:0] w_ack_onehot;
    logic [NUM_SRC-1:0] w_arm;
    logic               w_found;
    logic [ID_W-1:0]    w_pick;
    logic [ID_W-1:0]    w_start;
    logic [CNT_W-1:0]   w_count;

    assign w_ack    = eventValid && eventAck;
    assign w_arm_en = startOfFrame && !pause;

    // Arm vector: latched flags of enabled, cooled-down sources; a source acked
    // this same cycle is excluded because its cooldown is being reloaded
    always_comb begin
        w_ack_onehot = '0;
        if (w_ack) begin
            w_ack_onehot[r_id] = 1'b1;
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            w_cd_zero[s] = (r_cd[s] == '0);
        end
        w_arm = w_arm_en ? (r_frame_latch & srcMask & w_cd_zero & ~w_ack_onehot) : '0;
    end

    // Frame latch: accumulates while running; the strobe cycle seeds a fresh frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_latch <= '0;
        end else if (!pause) begin
            r_frame_latch <= startOfFrame ? collisionReq : (r_frame_latch | collisionReq);
        end
    end

    // Pending vector: set by arm, cleared by the handshake; re-arm of a pending bit merges
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_ack_onehot) | w_arm;
            r_dropped <= |(w_arm & r_pending);
        end
    end

    // Cooldowns: reload on accept, otherwise count down once per unpaused frame
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (reset) begin
                r_cd[s] <= '0;
            end else if (w_ack_onehot[s]) begin
                r_cd[s] <= CD_W'(COOLDOWN_FRAMES);
            end else if (w_arm_en && (r_cd[s] != '0)) begin
                r_cd[s] <= r_cd[s] - CD_W'(1);
            end
        end
    end

`ifdef COLLISION_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_ptr;

    // Round-robin pointer moves past the id just accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_ack) begin
            r_ptr <= (r_id == ID_W'(NUM_SRC - 1)) ? '0 : (r_id + ID_W'(1));
        end
    end

    assign w_start = r_ptr;
`else
    assign w_start = '0;
`endif

    event_priority_picker #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_picker (
        .i_req   (r_pending),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // FSM state and presented id registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_id    <= '0;
        end else begin
            r_state <= w_state_next;
            r_id    <= w_id_next;
        end
    end

    // FSM next state: pick in IDLE when not paused, hold in ISSUE until accepted
    always_comb begin
        w_state_next = r_state;
        w_id_next    = r_id;
        eventValid   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_found && !pause) begin
                    w_state_next = ARB_ISSUE;
                    w_id_next    = w_pick;
                end
            end
            ARB_ISSUE: begin
                eventValid = 1'b1;
                if (eventAck) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    // Pending count includes the event currently presented
    always_comb begin
        w_count = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_count = w_count + CNT_W'(r_pending[s]);
        end
    end

    assign pendingCount = w_count;
    assign eventId      = r_id;
    assign droppedEvent = r_dropped;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_collision_event_arbiter.sv
// Bench for collision_event_arbiter: directed frame scenarios, a per-cycle
// reference model built from the frame/arm/issue rules, and literal checks.
// Honours COLLISION_ROUND_ROBIN_EN in its model.
module tb_collision_event_arbiter;
    import pinball_pkg::*;

    localparam int N   = 8;
    localparam int CDF = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       sof;
    logic       pause;
    logic       ack;
    logic [7:0] req;
    logic [7:0] mask;
    logic       valid;
    logic [2:0] id;
    logic [3:0] pcount;
    logic       dropped;
    arb_state_t dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    bit         m_live = 1'b0;
    bit [N-1:0] m_latch;
    bit [N-1:0] m_pend;
    int         m_cd [N];
    bit         m_valid;
    int         m_id;
    bit         m_dropped;
    int         m_ptr;

    always #5 clk = ~clk;

    collision_event_arbiter #(
        .NUM_SRC         (N),
        .COOLDOWN_FRAMES (CDF),
        .CD_W            (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (sof),
        .pause        (pause),
        .collisionReq (req),
        .srcMask      (mask),
        .eventValid   (valid),
        .eventId      (id),
        .eventAck     (ack),
        .pendingCount (pcount),
        .droppedEvent (dropped),
        .o_dbg_state  (dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the model, using the inputs seen at this edge
    task automatic model_step();
        bit ackf;
        bit arm;
        bit found;
        int pick;
        int st;
        int s;
        if (reset) begin
            m_latch   = '0;
            m_pend    = '0;
            for (int k = 0; k < N; k++) m_cd[k] = 0;
            m_valid   = 1'b0;
            m_id      = 0;
            m_dropped = 1'b0;
            m_ptr     = 0;
            m_live    = 1'b1;
            return;
        end
        if (!m_live) return;
        ackf = m_valid && ack;
`ifdef COLLISION_ROUND_ROBIN_EN
        st = m_ptr;
`else
        st = 0;
`endif
        found = 1'b0;
        pick  = 0;
        if (!m_valid && !pause) begin
            for (int k = 0; k < N; k++) begin
                s = (st + k) % N;
                if (!found && m_pend[s]) begin
                    found = 1'b1;
                    pick  = s;
                end
            end
        end
        m_dropped = 1'b0;
        if (sof && !pause) begin
            for (int k = 0; k < N; k++) begin
                arm = m_latch[k] && mask[k] && (m_cd[k] == 0) && !(ackf && m_id == k);
                if (arm && m_pend[k]) m_dropped = 1'b1;
                if (m_cd[k] > 0) m_cd[k] = m_cd[k] - 1;
                m_latch[k] = req[k];
                if (arm) m_pend[k] = 1'b1;
            end
        end else if (!pause) begin
            m_latch = m_latch | req;
        end
        if (ackf) begin
            m_pend[m_id] = 1'b0;
            m_cd[m_id]   = CDF;
            m_ptr        = (m_id + 1) % N;
            m_valid      = 1'b0;
        end else if (found) begin
            m_valid = 1'b1;
            m_id    = pick;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("m_valid", valid, m_valid);
                if (m_valid) check("m_id", id, m_id);
                check("m_pcount", pcount, $countones(m_pend));
                check("m_dropped", dropped, m_dropped);
                check("m_state", dbg == ARB_ISSUE, m_valid);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sof_pulse();
        sof = 1'b1;
        tick(1);
        sof = 1'b0;
    endtask

    task automatic pulse_req(input int s);
        req[s] = 1'b1;
        tick(1);
        req[s] = 1'b0;
    endtask

    task automatic idle_frames(input int n);
        repeat (n) begin
            sof_pulse();
            tick(3);
        end
    endtask

    // Runs one frame of len cycles and counts cycles with eventValid high
    task automatic count_frame(input int len, output int cnt);
        sof_pulse();
        cnt = 0;
        repeat (len - 1) begin
            tick(1);
            if (valid === 1'b1) cnt++;
        end
    endtask

    logic [11:0] ev_mask;
    logic [2:0]  got_q[$];
    logic [2:0]  exp_q[$];
    int          cnt;

    initial begin
        reset = 1'b1; sof = 1'b0; pause = 1'b0; ack = 1'b0;
        req = '0; mask = 8'hFF;
        tick(3);
        check("rst_valid", valid, 0);
        check("rst_id", id, 0);
        check("rst_pcount", pcount, 0);
        check("rst_dropped", dropped, 0);
        reset = 1'b0;
        tick(1);

        // 1: single mid-frame pulse on source 2, ack tied high
        ack = 1'b1;
        sof_pulse(); tick(3); pulse_req(2); tick(2);
        sof_pulse();
        check("t1_pcount_armed", pcount, 1);
        check("t1_valid_early", valid, 0);
        tick(1);
        check("t1_valid", valid, 1);
        check("t1_id", id, 2);
        check("t1_pcount_issue", pcount, 1);
        tick(1);
        check("t1_valid_done", valid, 0);
        check("t1_pcount_done", pcount, 0);
        idle_frames(5);

        // 2: sources 7 and 0 together, ack withheld for 5 cycles
        ack = 1'b0;
        sof_pulse(); tick(2);
        req[7] = 1'b1; req[0] = 1'b1; tick(1); req = '0; tick(2);
        sof_pulse();
        check("t2_pcount", pcount, 2);
        tick(1);
        for (int k = 0; k < 5; k++) begin
            check("t2_hold_valid", valid, 1);
            check("t2_hold_id", id, 0);
            tick(1);
        end
        check("t2_last_valid", valid, 1);
        check("t2_last_id", id, 0);
        ack = 1'b1; tick(1); ack = 1'b0;
        check("t2_gap_valid", valid, 0);
        check("t2_gap_pcount", pcount, 1);
        tick(1);
        check("t2_second_valid", valid, 1);
        check("t2_second_id", id, 7);
        ack = 1'b1; tick(1);
        check("t2_end_pcount", pcount, 0);
        idle_frames(5);

        // 3: source 3 held every frame, cooldown spaces events 5 frames apart
        ack = 1'b1; req[3] = 1'b1; ev_mask = '0;
        for (int f = 0; f < 12; f++) begin
            sof_pulse();
            for (int t = 0; t < 3; t++) begin
                tick(1);
                if (valid === 1'b1 && id === 3'd3) ev_mask[f] = 1'b1;
            end
        end
        req = '0;
        check("t3_event_frames", ev_mask, 12'h842);
        idle_frames(6);

        // 4: re-arm of a still-pending source merges and flags a drop
        ack = 1'b0;
        sof_pulse(); tick(1); pulse_req(1); tick(1);
        sof_pulse(); tick(1);
        check("t4_valid", valid, 1);
        check("t4_id", id, 1);
        pulse_req(1); tick(1);
        sof_pulse();
        check("t4_dropped", dropped, 1);
        check("t4_pcount", pcount, 1);
        tick(1);
        check("t4_dropped_clear", dropped, 0);
        ack = 1'b1; tick(1);
        check("t4_valid_done", valid, 0);
        check("t4_pcount_done", pcount, 0);
        count_frame(4, cnt); check("t4_no_repeat_a", cnt, 0);
        count_frame(4, cnt); check("t4_no_repeat_b", cnt, 0);
        idle_frames(5);

        // 5: paused frame is discarded; masked source never issues
        ack = 1'b1; pause = 1'b1;
        sof_pulse(); tick(1); pulse_req(4); tick(1);
        sof_pulse(); tick(3);
        check("t5_pause_valid", valid, 0);
        check("t5_pause_pcount", pcount, 0);
        pause = 1'b0;
        count_frame(4, cnt); check("t5_after_pause", cnt, 0);
        mask[6] = 1'b0;
        sof_pulse(); pulse_req(6); tick(1);
        count_frame(4, cnt); check("t5_masked", cnt, 0);
        mask = 8'hFF;
        // 5b: a presented event survives pause and is still accepted
        ack = 1'b0;
        sof_pulse(); pulse_req(4); tick(1);
        sof_pulse(); tick(1);
        check("t5_issue_id", id, 4);
        pause = 1'b1; tick(2);
        check("t5_held_valid", valid, 1);
        check("t5_held_id", id, 4);
        ack = 1'b1; tick(1);
        check("t5_acked", valid, 0);
        ack = 1'b0; pause = 1'b0;
        idle_frames(5);

        // 6: sources 0 and 5 every frame alternate 0,5,0,5
        ack = 1'b1; req[0] = 1'b1; req[5] = 1'b1;
        exp_q = '{3'd0, 3'd5, 3'd0, 3'd5};
        for (int f = 0; f < 8; f++) begin
            sof_pulse();
            for (int t = 0; t < 5; t++) begin
                tick(1);
                if (valid === 1'b1) got_q.push_back(id);
            end
        end
        req = '0;
        check("t6_count", got_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check("t6_order", (k < got_q.size()) ? got_q[k] : 3'bx, exp_q[k]);
        end
        idle_frames(5);

        // 7: reset during a handshake clears everything
        ack = 1'b0;
        sof_pulse(); pulse_req(5); tick(1);
        sof_pulse(); tick(1);
        check("t7_valid", valid, 1);
        check("t7_id", id, 5);
        reset = 1'b1; tick(1);
        check("t7_rst_valid", valid, 0);
        check("t7_rst_pcount", pcount, 0);
        reset = 1'b0;
        count_frame(4, cnt); check("t7_clean_frame", cnt, 0);
        sof_pulse(); pulse_req(5); tick(1);
        sof_pulse(); tick(1);
        check("t7_reissue_valid", valid, 1);
        check("t7_reissue_id", id, 5);
        ack = 1'b1; tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
